// File: rtl/sprite_pkg.sv
// sprite_pkg: shared constants and types for the sprite BRAM write path.
package sprite_pkg;
  localparam int SPRITE_DW = 16;
  localparam int SPRITE_AW = 9;
  localparam int SPRITE_DEPTH = 400;
  typedef enum logic {ST_IDLE, ST_WRITE} wr_state_e;
  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;
endpackage

// File: rtl/sprite_wr_addr_gen.sv
// sprite_wr_addr_gen: wrap-around write pointer and remaining-word counter.
module sprite_wr_addr_gen #(
  parameter int ADDR_W = 9,
  parameter int DEPTH = 400
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] ptr,
  output logic              last
);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0] rem_q, rem_d;
  always_comb begin
    ptr_d = load ? base : step ? (ptr_q == LAST_A ? '0 : ptr_q + 1'b1) : ptr_q;
    rem_d = load ? len : step ? rem_q - 1'b1 : rem_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr_q <= '0;
      rem_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      rem_q <= rem_d;
    end
  assign ptr = ptr_q;
  assign last = rem_q == (ADDR_W+1)'(1);
endmodule

// File: rtl/sprite_ram_writer.sv
// sprite_ram_writer: streams a run of words into a sprite BRAM write port.
// Define SPRITE_WR_CKSUM_EN to add the running cksum output.
module sprite_ram_writer
  import sprite_pkg::*;
#(
  parameter int DATA_W = SPRITE_DW,
  parameter int ADDR_W = SPRITE_AW,
  parameter int DEPTH = SPRITE_DEPTH
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dia,
  output logic              wea,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef SPRITE_WR_CKSUM_EN
  ,
  output logic [DATA_W-1:0] cksum
`endif
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  wr_state_e state_q, state_d;
  logic [ADDR_W-1:0] addra_q, ptr;
  logic [DATA_W-1:0] dia_q;
  logic wea_q, done_q, done_d, err_q, err_d;
  logic idle, bad, load, hs, last;
  assign idle = state_q == ST_IDLE;
  assign bad = {1'b0, base_addr} >= DEPTH_L || len > DEPTH_L;
  assign load = idle && start && !bad && len != '0;
  assign hs = s_valid && s_ready;
  always_ff @(posedge clka or posedge rsta)
    if (rsta) state_q <= ST_IDLE;
    else state_q <= state_d;
  always_comb
    state_d = idle ? (load ? ST_WRITE : ST_IDLE)
                   : (abort || (hs && last)) ? ST_IDLE : ST_WRITE;
  always_comb begin
    s_ready = state_q == ST_WRITE && !abort;
    busy = state_q == ST_WRITE;
  end
  // err wins over the zero-length done when both apply
  always_comb begin
    err_d = idle && start && bad;
    done_d = (hs && last) || (idle && start && !bad && len == '0);
  end
  sprite_wr_addr_gen #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_addr (
    .clk (clka),
    .rst (rsta),
    .load(load),
    .step(hs),
    .base(base_addr),
    .len (len),
    .ptr (ptr),
    .last(last)
  );
  always_ff @(posedge clka or posedge rsta)
    if (rsta) begin
      addra_q <= '0;
      dia_q <= '0;
      wea_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      wea_q <= hs;
      done_q <= done_d;
      err_q <= err_d;
      if (hs) begin
        addra_q <= ptr;
        dia_q <= s_data;
      end
    end
  assign addra = addra_q;
  assign dia = dia_q;
  assign wea = wea_q;
  assign done = done_q;
  assign err = err_q;
`ifdef SPRITE_WR_CKSUM_EN
  logic [DATA_W-1:0] cksum_q;
  always_ff @(posedge clka or posedge rsta)
    if (rsta) cksum_q <= '0;
    else if (load) cksum_q <= '0;
    else if (hs) cksum_q <= cksum_q + s_data;
  assign cksum = cksum_q;
`endif
endmodule

// File: tb/tb_sprite_ram_writer.sv
// tb_sprite_ram_writer: run-level model checked every cycle plus literal write logs.
module tb_sprite_ram_writer;
  logic clka = 0, rsta = 1, start = 0, abort = 0, s_valid = 0;
  logic [8:0] base_addr = 0;
  logic [9:0] len = 0;
  logic [15:0] s_data = 0;
  logic s_ready, wea, busy, done, err;
  logic [8:0] addra;
  logic [15:0] dia;
`ifdef SPRITE_WR_CKSUM_EN
  logic [15:0] cksum;
`endif
  int passed = 0, total = 0, done_seen = 0, err_seen = 0;
  int log_a[$], log_d[$];

  sprite_ram_writer dut (
    .clka(clka), .rsta(rsta), .start(start), .base_addr(base_addr), .len(len),
    .abort(abort), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .addra(addra), .dia(dia), .wea(wea), .busy(busy), .done(done), .err(err)
`ifdef SPRITE_WR_CKSUM_EN
    , .cksum(cksum)
`endif
  );

  always #5 clka = ~clka;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
  endtask

  // Run-level model: a run is (base, len, words written); address is (base+k) mod 400.
  bit m_busy;
  int m_base, m_len, m_k;
  bit e_wea, e_done, e_err;
  int e_addr, e_dia, e_ck;
  always @(posedge clka or posedge rsta)
    if (rsta) begin
      m_busy <= 0; m_k <= 0; e_wea <= 0; e_done <= 0; e_err <= 0;
      e_addr <= 0; e_dia <= 0; e_ck <= 0;
    end else begin
      e_wea <= 0; e_done <= 0; e_err <= 0;
      if (!m_busy) begin
        if (start) begin
          if (base_addr >= 400 || len > 400) e_err <= 1;
          else if (len == 0) e_done <= 1;
          else begin
            m_busy <= 1; m_base <= base_addr; m_len <= len; m_k <= 0; e_ck <= 0;
          end
        end
      end else if (abort) m_busy <= 0;
      else if (s_valid) begin
        e_wea <= 1;
        e_addr <= (m_base + m_k) % 400;
        e_dia <= s_data;
        e_ck <= (e_ck + s_data) % 65536;
        m_k <= m_k + 1;
        if (m_k + 1 == m_len) begin
          m_busy <= 0;
          e_done <= 1;
        end
      end
    end

  always @(negedge clka) begin
    chk("wea", wea, e_wea);
    chk("addra", addra, e_addr);
    chk("dia", dia, e_dia);
    chk("busy", busy, m_busy);
    chk("done", done, e_done);
    chk("err", err, e_err);
    chk("s_ready", s_ready, m_busy && !abort);
`ifdef SPRITE_WR_CKSUM_EN
    chk("cksum", cksum, e_ck);
`endif
    if (wea) begin
      log_a.push_back(addra);
      log_d.push_back(dia);
    end
    if (done) done_seen++;
    if (err) err_seen++;
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clka);
      #1;
    end
  endtask

  task automatic go(input int b, input int l);
    start = 1; base_addr = 9'(b); len = 10'(l);
    cyc();
    start = 0;
  endtask

  task automatic send(input int d, input bit v);
    s_valid = v; s_data = 16'(d);
    cyc();
    s_valid = 0;
  endtask

  task automatic check_log(input string name, input int a[], input int d[]);
    chk({name, "_count"}, log_a.size(), a.size());
    for (int i = 0; i < a.size() && i < log_a.size(); i++) begin
      chk({name, "_addr"}, log_a[i], a[i]);
      chk({name, "_data"}, log_d[i], d[i]);
    end
    log_a.delete();
    log_d.delete();
  endtask

  initial begin
    cyc(2);
    chk("rst_busy", busy, 0);
    chk("rst_wea", wea, 0);
    chk("rst_ready", s_ready, 0);
    rsta = 0;
    cyc(2);
    // back-to-back run at base 0
    go(0, 4);
    chk("busy_after_start", busy, 1);
    send('h1111, 1); send('h2222, 1); send('h3333, 1);
    s_valid = 1; s_data = 16'h4444;
    cyc();
    s_valid = 0;
    chk("done_with_last_wea", {done, wea, busy}, 3'b110);
`ifdef SPRITE_WR_CKSUM_EN
    chk("cksum_lit", cksum, 'hAAAA);
`endif
    cyc(2);
    check_log("run0", '{0, 1, 2, 3}, '{'h1111, 'h2222, 'h3333, 'h4444});
    // wrap at the top of the BRAM
    go(398, 4);
    for (int i = 0; i < 4; i++) send('hA000 + i, 1);
    cyc(2);
    check_log("wrap", '{398, 399, 0, 1}, '{'hA000, 'hA001, 'hA002, 'hA003});
    // zero length and illegal parameters
    done_seen = 0; err_seen = 0;
    go(7, 0); cyc(2);
    chk("len0_done", done_seen, 1);
    go(400, 1); cyc(2);
    go(10, 401); cyc(2);
    go(400, 0); cyc(2);
    chk("err_count", err_seen, 3);
    chk("len0_done_only", done_seen, 1);
    check_log("none", '{}, '{});
    // gapped stream
    go(100, 3);
    send('h0B01, 1); send('hDEAD, 0); send('h0B02, 1); send('hBEEF, 0); send('h0B03, 1);
    cyc(2);
    check_log("gap", '{100, 101, 102}, '{'h0B01, 'h0B02, 'h0B03});
    // abort after two of five, then a fresh run
    done_seen = 0;
    go(20, 5);
    send('h0C01, 1); send('h0C02, 1);
    abort = 1; s_valid = 1; s_data = 16'h0C03;
    #1 chk("ready_in_abort", s_ready, 0);
    cyc();
    abort = 0; s_valid = 0;
    chk("busy_after_abort", busy, 0);
    cyc(2);
    chk("abort_no_done", done_seen, 0);
    check_log("abort", '{20, 21}, '{'h0C01, 'h0C02});
    go(30, 2);
    send('h0D01, 1); send('h0D02, 1);
    cyc(2);
    check_log("after_abort", '{30, 31}, '{'h0D01, 'h0D02});
    // asynchronous reset between edges
    go(50, 4);
    send('h0E01, 1);
    s_valid = 1; s_data = 16'h0E02;
    #2 rsta = 1;
    #1;
    chk("arst_vec", {wea, busy, done, err, s_ready}, 0);
    chk("arst_addra", addra, 0);
    chk("arst_dia", dia, 0);
    s_valid = 0;
    @(negedge clka);
    #2 rsta = 0;
    cyc();
    log_a.delete();
    log_d.delete();
    go(5, 2);
    send('h0F01, 1); send('h0F02, 1);
    cyc(2);
    check_log("post_reset", '{5, 6}, '{'h0F01, 'h0F02});
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
